// File: rtl/kyber_pkg.sv
// Shared Kyber datapath definitions: modulus, polynomial length, coefficient
// and field-width types, and the byte decoder state encoding.
package kyber_pkg;

  localparam int Q = 3329;
  localparam int N = 256;

  typedef logic [15:0] coef_t;
  typedef logic [3:0]  dsel_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } bd_state_e;

endpackage

// File: rtl/byte_decode_unpacker_if.sv
// Control, packed-byte input and coefficient output bundle of the byte decoder.
// The master side drives start/bytes/out_ready; the slave side is the decoder.
interface byte_decode_unpacker_if;
  import kyber_pkg::*;

  logic       start;
  dsel_t      d_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       out_valid;
  logic       out_ready;
  coef_t      out_coef;
  coef_t      out_d;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, d_sel, in_valid, in_byte, out_ready,
    input  in_ready, out_valid, out_coef, out_d, out_last, busy, done, err
  );

  modport slave (
    input  start, d_sel, in_valid, in_byte, out_ready,
    output in_ready, out_valid, out_coef, out_d, out_last, busy, done, err
  );

endinterface

// File: rtl/bd_bit_buffer.sv
// LSB-first bit accumulator: bytes are appended above the live bits and
// completed d-bit fields are shifted out from the bottom.
module bd_bit_buffer
  import kyber_pkg::*;
#(
  parameter int BUFW = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        wr_en,
  input  logic [7:0]  wr_byte,
  input  logic        shift_en,
  input  dsel_t       d,
  output logic [15:0] head,
  output logic [4:0]  bit_cnt
);

  logic [BUFW-1:0] buf_p0;

  // Bits at and above bit_cnt are always zero, so an OR performs the append.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_p0  <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      buf_p0  <= '0;
      bit_cnt <= '0;
    end else if (wr_en) begin
      buf_p0  <= buf_p0 | (BUFW'(wr_byte) << bit_cnt);
      bit_cnt <= bit_cnt + 5'd8;
    end else if (shift_en) begin
      buf_p0  <= buf_p0 >> d;
      bit_cnt <= bit_cnt - 5'(d);
    end
  end

  assign head = buf_p0[15:0];

endmodule

// File: rtl/byte_decode_unpacker.sv
// Streaming ByteDecode_d: unpacks 256 little-endian d-bit fields per polynomial.
// Optional BYTE_DECODE_REDUCE_EN folds d=12 fields >= Q down by one Q.
module byte_decode_unpacker #(
  parameter int Q    = kyber_pkg::Q,
  parameter int N    = kyber_pkg::N,
  parameter int BUFW = 20
) (
  input logic                   clk,
  input logic                   rst_n,
  byte_decode_unpacker_if.slave bus
);
  import kyber_pkg::*;

  // Widest legal field is the bit length of the modulus.
  localparam int DMAX = $clog2(Q);
  localparam int CW   = $clog2(N);

  bd_state_e     state, state_nxt;
  dsel_t         d_q;
  logic [CW-1:0] coef_cnt;
  logic [15:0]   head;
  logic [4:0]    bit_cnt;
  logic          done_q, err_q;
  logic          busy, in_rdy, vld_p0, in_hs, out_hs, last_idx;
  logic          start_idle, start_ok, start_bad;
  coef_t         raw;

  function automatic logic d_legal(input dsel_t d);
    return (d != 4'd0) && (int'(d) <= DMAX);
  endfunction

  function automatic coef_t field_extract(input logic [15:0] h, input dsel_t d);
    coef_t mask;
    mask = coef_t'((17'd1 << d) - 17'd1);
    return h & mask;
  endfunction

`ifdef BYTE_DECODE_REDUCE_EN
  function automatic coef_t reduce_q(input coef_t x, input dsel_t d);
    if ((d == 4'd12) && (x >= coef_t'(Q))) return x - coef_t'(Q);
    return x;
  endfunction
`endif

  assign busy       = (state == RUN);
  assign start_idle = (state == IDLE) && bus.start;
  assign start_ok   = start_idle && d_legal(bus.d_sel);
  assign start_bad  = start_idle && !d_legal(bus.d_sel);
  assign in_rdy     = busy && (bit_cnt < 5'(d_q));
  assign vld_p0     = busy && (bit_cnt >= 5'(d_q));
  assign in_hs      = bus.in_valid && in_rdy;
  assign out_hs     = vld_p0 && bus.out_ready;
  assign last_idx   = (coef_cnt == CW'(N - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (out_hs && last_idx) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      d_q      <= '0;
      coef_cnt <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= out_hs && last_idx;
      err_q  <= start_bad;
      if (start_ok) begin
        d_q      <= bus.d_sel;
        coef_cnt <= '0;
      end else if (out_hs) begin
        coef_cnt <= coef_cnt + 1'b1;
      end
    end
  end

  bd_bit_buffer #(.BUFW(BUFW)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_ok),
    .wr_en    (in_hs),
    .wr_byte  (bus.in_byte),
    .shift_en (out_hs),
    .d        (d_q),
    .head     (head),
    .bit_cnt  (bit_cnt)
  );

  // Output stage: field mask (and optional fold) straight off the buffer register.
  assign raw = field_extract(head, d_q);
`ifdef BYTE_DECODE_REDUCE_EN
  assign bus.out_coef = reduce_q(raw, d_q);
`else
  assign bus.out_coef = raw;
`endif

  assign bus.out_d     = coef_t'(d_q);
  assign bus.out_valid = vld_p0;
  assign bus.out_last  = vld_p0 && last_idx;
  assign bus.in_ready  = in_rdy;
  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_byte_decode_unpacker.sv
// Scoreboard bench for byte_decode_unpacker: directed polynomials are queued
// as expected coefficients and a negedge monitor checks every output handshake.
module tb_byte_decode_unpacker;

  typedef struct {
    int coef;
    int d;
    int last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  byte_decode_unpacker_if bus();

  byte_decode_unpacker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_acc = 0;
  exp_t sb[$];
  exp_t e;
  int   pre_q[$];
  logic [7:0] byte_q[$];

`ifdef BYTE_DECODE_REDUCE_EN
  localparam int FULL12 = 766;
`else
  localparam int FULL12 = 4095;
`endif

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_coef: got %0d expected none", bus.out_coef);
      end else begin
        e = sb.pop_front();
        check("out_coef", int'(bus.out_coef), e.coef);
        check("out_d", int'(bus.out_d), e.d);
        check("out_last", int'(bus.out_last), e.last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int d);
    bus.start = 1'b1;
    bus.d_sel = 4'(d);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (bus.in_ready) ok = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    if (ok) n_acc++;
    else begin
      n_cmp++;
      n_err++;
      $display("FAIL byte_accept_timeout: got in_ready=0 expected 1");
    end
  endtask

  task automatic push_poly(input int d, input int fill);
    for (int i = 0; i < 256; i++) begin
      exp_t x;
      x.coef = (i < pre_q.size()) ? pre_q[i] : fill;
      x.d    = d;
      x.last = (i == 255) ? 1 : 0;
      sb.push_back(x);
    end
    pre_q.delete();
  endtask

  task automatic send_poly(input int n, input logic [7:0] fill);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = (i < byte_q.size()) ? byte_q[i] : fill;
      send_byte(b);
    end
    byte_q.delete();
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!bus.done && k < 2000) begin
      tick();
      k++;
    end
    check("done_seen", int'(bus.done), 1);
    check("busy_at_done", int'(bus.busy), 0);
    check("err_with_done", int'(bus.err), 0);
    check("sb_drained", sb.size(), 0);
    tick();
    check("done_one_cycle", int'(bus.done), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.d_sel = '0;
    bus.in_valid = 1'b0;
    bus.in_byte = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_out_coef", int'(bus.out_coef), 0);
    check("rst_out_d", int'(bus.out_d), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // d=11: 0x04,0x04 -> 1028
    pre_q.push_back(1028);
    push_poly(11, 0);
    do_start(11);
    check("d11_busy", int'(bus.busy), 1);
    check("d11_in_ready", int'(bus.in_ready), 1);
    send_byte(8'h04);
    check("d11_no_valid_one_byte", int'(bus.out_valid), 0);
    send_byte(8'h04);
    check("d11_valid_after_2nd", int'(bus.out_valid), 1);
    send_poly(350, 8'h00);
    wait_done();

    // d=4: 0xA5 -> 5, 10 with in_ready low while emitting
    pre_q.push_back(5);
    pre_q.push_back(10);
    push_poly(4, 0);
    do_start(4);
    send_byte(8'hA5);
    check("d4_valid0", int'(bus.out_valid), 1);
    check("d4_in_ready0", int'(bus.in_ready), 0);
    tick();
    check("d4_valid1", int'(bus.out_valid), 1);
    check("d4_in_ready1", int'(bus.in_ready), 0);
    tick();
    check("d4_valid_drop", int'(bus.out_valid), 0);
    check("d4_in_ready_back", int'(bus.in_ready), 1);
    send_poly(127, 8'h00);
    wait_done();

    // d=1: 32 x 0xFF -> 256 ones, exactly 32 bytes taken
    push_poly(1, 1);
    n_acc = 0;
    do_start(1);
    send_poly(32, 8'hFF);
    wait_done();
    check("d1_bytes_accepted", n_acc, 32);
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      check("idle_in_ready", int'(bus.in_ready), 0);
      tick();
    end
    bus.in_valid = 1'b0;

    // d=10: stall with out_ready low for 5 cycles
    bus.out_ready = 1'b0;
    pre_q.push_back(564);
    pre_q.push_back(4);
    push_poly(10, 0);
    do_start(10);
    send_byte(8'h34);
    send_byte(8'h12);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", int'(bus.out_valid), 1);
      check("stall_coef", int'(bus.out_coef), 564);
      check("stall_last", int'(bus.out_last), 0);
      check("stall_in_ready", int'(bus.in_ready), 0);
      tick();
    end
    check("stall_sb_untouched", sb.size(), 256);
    bus.out_ready = 1'b1;
    send_poly(318, 8'h00);
    wait_done();

    // d=12: 0xFF x3 -> two full-scale fields
    pre_q.push_back(FULL12);
    pre_q.push_back(FULL12);
    push_poly(12, 0);
    do_start(12);
    byte_q.push_back(8'hFF);
    byte_q.push_back(8'hFF);
    byte_q.push_back(8'hFF);
    send_poly(384, 8'h00);
    wait_done();

    // Illegal d values
    bus.d_sel = 4'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("err_d0_pulse", int'(bus.err), 1);
    check("err_d0_busy", int'(bus.busy), 0);
    check("err_d0_done", int'(bus.done), 0);
    tick();
    check("err_d0_width", int'(bus.err), 0);
    check("err_d0_busy2", int'(bus.busy), 0);
    bus.d_sel = 4'd13;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("err_d13_pulse", int'(bus.err), 1);
    check("err_d13_busy", int'(bus.busy), 0);
    tick();

    // Reset after 10 coefficients, then a fresh polynomial
    for (int i = 1; i <= 10; i++) sb.push_back('{i, 8, 0});
    do_start(8);
    for (int i = 1; i <= 10; i++) send_byte(8'(i));
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    check("pre_reset_drained", sb.size(), 0);
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(bus.busy), 0);
    check("arst_in_ready", int'(bus.in_ready), 0);
    check("arst_out_valid", int'(bus.out_valid), 0);
    check("arst_out_coef", int'(bus.out_coef), 0);
    check("arst_out_d", int'(bus.out_d), 0);
    check("arst_out_last", int'(bus.out_last), 0);
    check("arst_done", int'(bus.done), 0);
    check("arst_err", int'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pre_q.push_back(171);
    push_poly(8, 0);
    do_start(8);
    byte_q.push_back(8'hAB);
    send_poly(256, 8'h00);
    wait_done();

    check("final_sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
